// File: rtl/video_pkg.sv
// Shared video-link definitions: TMDS control tokens, their {C1,C0} codes and
// the receive-deserializer state type.
package video_pkg;

  localparam logic [9:0] TOKEN_C00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_C01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_C10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_C11 = 10'b1010101011;

  localparam logic [1:0] CTRL_C00 = 2'b00;
  localparam logic [1:0] CTRL_C01 = 2'b01;
  localparam logic [1:0] CTRL_C10 = 2'b10;
  localparam logic [1:0] CTRL_C11 = 2'b11;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } deser_state_t;

endpackage

// File: rtl/ctrl_token_detect.sv
// Combinational recogniser for the four TMDS control tokens; shared with the
// 10b/8b decoder.
module ctrl_token_detect
  import video_pkg::*;
(
  input  logic [9:0] word_i,
  output logic       is_ctrl_o,
  output logic [1:0] ctrl_o
);

  // Exact compare against each token; anything else is a data word.
  always_comb begin
    is_ctrl_o = 1'b0;
    ctrl_o    = CTRL_C00;
    case (word_i)
      TOKEN_C00: begin is_ctrl_o = 1'b1; ctrl_o = CTRL_C00; end
      TOKEN_C01: begin is_ctrl_o = 1'b1; ctrl_o = CTRL_C01; end
      TOKEN_C10: begin is_ctrl_o = 1'b1; ctrl_o = CTRL_C10; end
      TOKEN_C11: begin is_ctrl_o = 1'b1; ctrl_o = CTRL_C11; end
      default:   begin is_ctrl_o = 1'b0; ctrl_o = 2'b00;    end
    endcase
  end

endmodule

// File: rtl/deserializer.sv
// 1:10 receive deserializer: finds the word boundary from blanking control
// tokens and emits aligned 10-bit words once every 10 bit-clocks while locked.
module deserializer
  import video_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial,
  input  logic       realign,
  output logic [9:0] data,
  output logic       data_valid,
  output logic       is_ctrl,
  output logic [1:0] ctrl,
  output logic       locked
);

  localparam logic [3:0] LOCK_TARGET = LOCK_COUNT[3:0];

  logic [9:0]   sr_q, sr_d;
  logic [3:0]   bit_cnt_q, bit_cnt_d;
  logic [3:0]   match_cnt_q, match_cnt_d;
  deser_state_t state_q, state_d;
  logic [9:0]   data_q, data_d;
  logic         valid_q, valid_d;
  logic         is_ctrl_q, is_ctrl_d;
  logic [1:0]   ctrl_q, ctrl_d;
  logic         locked_q, locked_d;

  logic         tok_hit_s;
  logic [1:0]   tok_ctrl_s;
  logic         boundary_s;
  logic [3:0]   match_inc_s;

  ctrl_token_detect u_tok (
    .word_i    (sr_q),
    .is_ctrl_o (tok_hit_s),
    .ctrl_o    (tok_ctrl_s)
  );

  assign boundary_s  = (bit_cnt_q == 4'd9);
  assign match_inc_s = match_cnt_q + 4'd1;

  // Next-state: shifting, word counter, alignment FSM and output capture.
  always_comb begin
    sr_d        = {serial, sr_q[9:1]};
    bit_cnt_d   = boundary_s ? 4'd0 : (bit_cnt_q + 4'd1);
    match_cnt_d = match_cnt_q;
    state_d     = state_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    is_ctrl_d   = is_ctrl_q;
    ctrl_d      = ctrl_q;

    if (realign) begin
      // A match seen while realigning is discarded; the counter keeps running.
      state_d     = HUNT;
      match_cnt_d = 4'd0;
    end else begin
      case (state_q)
        HUNT: begin
          if (tok_hit_s) begin
            bit_cnt_d   = 4'd0;
            match_cnt_d = 4'd1;
            state_d     = (LOCK_TARGET == 4'd1) ? LOCKED : VERIFY;
          end else begin
            state_d = HUNT;
          end
        end
        VERIFY: begin
          if (boundary_s && tok_hit_s) begin
            match_cnt_d = match_inc_s;
            state_d     = (match_inc_s >= LOCK_TARGET) ? LOCKED : VERIFY;
          end else if (boundary_s) begin
            match_cnt_d = 4'd0;
            state_d     = HUNT;
          end else begin
            state_d = VERIFY;
          end
        end
        LOCKED: begin
          state_d = LOCKED;
        end
        default: begin
          state_d     = HUNT;
          match_cnt_d = 4'd0;
        end
      endcase
    end

    // The word in flight is still delivered on the edge a realign arrives.
    if ((state_q == LOCKED) && boundary_s) begin
      data_d    = sr_q;
      valid_d   = 1'b1;
      is_ctrl_d = tok_hit_s;
      ctrl_d    = tok_ctrl_s;
    end else begin
      valid_d = 1'b0;
    end

    locked_d = (state_d == LOCKED);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q        <= 10'd0;
      bit_cnt_q   <= 4'd0;
      match_cnt_q <= 4'd0;
      state_q     <= HUNT;
      data_q      <= 10'd0;
      valid_q     <= 1'b0;
      is_ctrl_q   <= 1'b0;
      ctrl_q      <= 2'b00;
      locked_q    <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      match_cnt_q <= match_cnt_d;
      state_q     <= state_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      is_ctrl_q   <= is_ctrl_d;
      ctrl_q      <= ctrl_d;
      locked_q    <= locked_d;
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign is_ctrl    = is_ctrl_q;
  assign ctrl       = ctrl_q;
  assign locked     = locked_q;

endmodule
